// File: rtl/dmem_io_pkg.sv
// Shared encodings for the data-memory / UART I/O block: store sizes, load types,
// address map constants and the UART transmitter state enum.
package dmem_io_pkg;

    localparam logic [1:0] DMS_W   = 2'b00;
    localparam logic [1:0] DMS_H   = 2'b01;
    localparam logic [1:0] DMS_B   = 2'b10;
    localparam logic [1:0] DMS_NOP = 2'b11;

    localparam logic [2:0] DML_LW  = 3'b000;
    localparam logic [2:0] DML_LH  = 3'b001;
    localparam logic [2:0] DML_LHU = 3'b010;
    localparam logic [2:0] DML_LB  = 3'b011;
    localparam logic [2:0] DML_LBU = 3'b100;

    localparam logic [15:0] RAM_BASE_HI = 16'h1001;
    localparam logic [31:0] ADDR_TXDATA = 32'h1000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'h1000_0004;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/dmem_io_uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; the FSM pops one byte per frame
// while idle and holds every bit for CLK_DIV clocks.
module uart_tx_fifo
    import dmem_io_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       ovf_clr,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic       uart_tx
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          empty, pop, accept;

    tx_state_e     state, state_d;
    logic [BW-1:0] baud, baud_d;
    logic [2:0]    bit_cnt, bit_d;
    logic [7:0]    shift, shift_d;

    assign empty  = (count == '0);
    assign full   = (count == (PW+1)'(FIFO_DEPTH));
    // A pop frees a slot in the same cycle, so a push while full is still taken.
    assign accept = push && (!full || pop);
    assign busy   = !empty || (state != ST_IDLE);

    // NOTE: payload storage has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_clr)              overflow <= 1'b0;
            else if (push && !accept) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_d;
            baud    <= baud_d;
            bit_cnt <= bit_d;
            shift   <= shift_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_d = state;
        baud_d  = baud;
        bit_d   = bit_cnt;
        shift_d = shift;
        pop     = 1'b0;
        uart_tx = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr];
                    baud_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                uart_tx = 1'b0;
                if (baud == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            ST_DATA: begin
                uart_tx = shift[0];
                if (baud == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift[7:1]};
                    bit_d   = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state_d = ST_STOP;
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/dmem_io.sv
// Data memory and memory-mapped UART for a single-cycle CPU: byte-enabled RAM,
// sign/zero-extending loads, a TXDATA push register and a STATUS register.
module dmem_io
    import dmem_io_pkg::*;
#(
    parameter int MEM_WORDS  = 2048,
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        DM_W,
    input  logic [1:0]  DMS_mux,
    input  logic [2:0]  DML_mux,
    output logic [31:0] rdata,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int IW = $clog2(MEM_WORDS);

    logic [31:0]   mem [MEM_WORDS];
    logic [10:0]   word_sel;
    logic [IW-1:0] idx;
    logic          ram_sel, tx_sel, st_sel, store_en;
    logic [3:0]    be;
    logic [31:0]   wd, word_rd;
    logic [15:0]   lane_h;
    logic [7:0]    lane_b;
    logic          fifo_full, fifo_ovf;

    assign word_sel = addr[12:2];
    assign idx      = word_sel[IW-1:0];
    assign ram_sel  = (addr[31:16] == RAM_BASE_HI);
    assign tx_sel   = (addr == ADDR_TXDATA);
    assign st_sel   = (addr == ADDR_STATUS);
    assign store_en = DM_W && (DMS_mux != DMS_NOP);

    // Replicate store data across lanes; the byte enables pick which lanes land.
    always_comb begin
        be = 4'b0000;
        wd = wdata;
        case (DMS_mux)
            DMS_W: be = 4'b1111;
            DMS_H: begin
                be = addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata[15:0]}};
            end
            DMS_B: begin
                be = 4'b0001 << addr[1:0];
                wd = {4{wdata[7:0]}};
            end
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (store_en && ram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    assign word_rd = mem[idx];
    assign lane_h  = addr[1] ? word_rd[31:16] : word_rd[15:0];
    assign lane_b  = word_rd[{addr[1:0], 3'b000} +: 8];

    always_comb begin
        rdata = '0;
        if (ram_sel) begin
            case (DML_mux)
                DML_LW:  rdata = word_rd;
                DML_LH:  rdata = {{16{lane_h[15]}}, lane_h};
                DML_LHU: rdata = {16'h0000, lane_h};
                DML_LB:  rdata = {{24{lane_b[7]}}, lane_b};
                DML_LBU: rdata = {24'h000000, lane_b};
                default: rdata = '0;
            endcase
        end else if (st_sel) begin
            rdata = {29'd0, fifo_ovf, tx_busy, fifo_full};
        end
    end

    uart_tx_fifo #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .push      (store_en && tx_sel),
        .push_data (wdata[7:0]),
        .ovf_clr   (store_en && st_sel),
        .full      (fifo_full),
        .overflow  (fifo_ovf),
        .busy      (tx_busy),
        .uart_tx   (uart_tx)
    );

endmodule

// File: tb/tb_dmem_io.sv
// Directed bench for dmem_io: RAM lanes and extension, address decode, UART frame
// shape, FIFO overflow / simultaneous push-pop, and mid-frame reset.
module tb_dmem_io;
    import dmem_io_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata;
    logic        DM_W;
    logic [1:0]  DMS_mux;
    logic [2:0]  DML_mux;
    logic        uart_tx, tx_busy;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_io #(
        .MEM_WORDS  (2048),
        .CLK_DIV    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wdata   (wdata),
        .DM_W    (DM_W),
        .DMS_mux (DMS_mux),
        .DML_mux (DML_mux),
        .rdata   (rdata),
        .uart_tx (uart_tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Applies one cycle of inputs at the falling edge; the next rising edge consumes them.
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we,
                         input logic [1:0] sz, input logic [2:0] lt);
        @(negedge clk);
        addr    = a;
        wdata   = d;
        DM_W    = we;
        DMS_mux = sz;
        DML_mux = lt;
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [2:0] lt,
                        input logic [31:0] exp);
        drive(a, 32'h0, 1'b0, DMS_NOP, lt);
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        drive(a, d, 1'b1, sz, DML_LW);
    endtask

    task automatic wait_tx_low(input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (uart_tx === 1'b0) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        logic [9:0] exp_frame;
        logic       drained;
        int         bad_tx, bad_busy;

        rst = 1'b1; addr = '0; wdata = '0; DM_W = 1'b0; DMS_mux = DMS_NOP; DML_mux = DML_LW;
        #12;
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        addr = ADDR_STATUS;
        #1;
        check("rst_status", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // RAM lanes and extension
        store(32'h1001_0000, 32'hA1B2_C3D4, DMS_W);
        load("lb_1",   32'h1001_0001, DML_LB,  32'hFFFF_FFC3);
        load("lbu_1",  32'h1001_0001, DML_LBU, 32'h0000_00C3);
        load("lh_2",   32'h1001_0002, DML_LH,  32'hFFFF_A1B2);
        load("lhu_2",  32'h1001_0002, DML_LHU, 32'h0000_A1B2);
        load("lh_0",   32'h1001_0000, DML_LH,  32'hFFFF_C3D4);
        load("lw_0",   32'h1001_0000, DML_LW,  32'hA1B2_C3D4);
        store(32'h1001_0003, 32'h0000_0055, DMS_B);
        load("sb_3",   32'h1001_0000, DML_LW,  32'h55B2_C3D4);
        store(32'h1001_0000, 32'h0000_1234, DMS_H);
        load("sh_0",   32'h1001_0000, DML_LW,  32'h55B2_1234);
        load("lb_3",   32'h1001_0003, DML_LB,  32'h0000_0055);
        load("lbu_0",  32'h1001_0000, DML_LBU, 32'h0000_0034);
        store(32'h1001_0000, 32'hFFFF_FFFF, DMS_NOP);
        load("nop_st", 32'h1001_0000, DML_LW,  32'h55B2_1234);
        load("dml101", 32'h1001_0000, 3'b101,  32'h0);
        load("dml111", 32'h1001_0000, 3'b111,  32'h0);
        load("alias",  32'h1001_2000, DML_LW,  32'h55B2_1234);
        store(32'h1001_0006, 32'hCAFE_F00D, DMS_W);
        load("sw_mis", 32'h1001_0004, DML_LW,  32'hCAFE_F00D);
        store(32'h1001_0006, 32'h0000_9876, DMS_H);
        load("sh_hi",  32'h1001_0004, DML_LW,  32'h9876_F00D);
        load("w0_kept", 32'h1001_0000, DML_LW, 32'h55B2_1234);

        // Unmapped address
        store(32'h2000_0000, 32'h1234_5678, DMS_W);
        load("unmap_lw", 32'h2000_0000, DML_LW, 32'h0);
        load("unmap_ram", 32'h1001_0000, DML_LW, 32'h55B2_1234);
        load("unmap_st", ADDR_STATUS, DML_LW, 32'h0);
        load("txd_rd",   ADDR_TXDATA, DML_LW, 32'h0);

        // Single frame 8'hA5
        exp_frame = {1'b1, 8'hA5, 1'b0};
        store(ADDR_TXDATA, 32'hFFFF_FFA5, DMS_B);
        drive(32'h0, 32'h0, 1'b0, DMS_NOP, DML_LW);
        #1;
        check("busy_after_push", {31'd0, tx_busy}, 32'd1);
        check("idle_before_frame", {31'd0, uart_tx}, 32'd1);
        wait_tx_low("frame_start");
        bad_tx = 0;
        bad_busy = 0;
        for (int s = 0; s < 40; s++) begin
            if (s > 0) begin
                @(negedge clk);
                #1;
            end
            if (uart_tx !== exp_frame[s/4]) bad_tx++;
            if (tx_busy !== 1'b1) bad_busy++;
        end
        check("frame_bits_bad", bad_tx, 0);
        check("frame_busy_bad", bad_busy, 0);
        @(negedge clk);
        #1;
        check("after_frame_tx", {31'd0, uart_tx}, 32'd1);
        check("after_frame_busy", {31'd0, tx_busy}, 32'd0);

        // Overflow and simultaneous push/pop while full
        store(ADDR_TXDATA, 32'h11, DMS_W);
        drive(32'h0, 32'h0, 1'b0, DMS_NOP, DML_LW);
        store(ADDR_TXDATA, 32'h22, DMS_W);
        store(ADDR_TXDATA, 32'h33, DMS_H);
        store(ADDR_TXDATA, 32'h44, DMS_B);
        store(ADDR_TXDATA, 32'h55, DMS_W);
        store(ADDR_TXDATA, 32'h66, DMS_W);
        load("st_ovf", ADDR_STATUS, DML_LW, 32'h7);
        store(ADDR_STATUS, 32'h0, DMS_W);
        load("st_clr", ADDR_STATUS, DML_LW, 32'h3);
        repeat (32) drive(ADDR_STATUS, 32'h0, 1'b0, DMS_NOP, DML_LW);
        store(ADDR_TXDATA, 32'h77, DMS_W);
        load("st_pushpop", ADDR_STATUS, DML_LW, 32'h3);
        store(ADDR_TXDATA, 32'h88, DMS_W);
        load("st_drop", ADDR_STATUS, DML_LW, 32'h7);

        drained = 1'b0;
        for (int n = 0; n < 1000 && !drained; n++) begin
            drive(ADDR_STATUS, 32'h0, 1'b0, DMS_NOP, DML_LW);
            #1;
            if (tx_busy === 1'b0) drained = 1'b1;
        end
        check("drained", {31'd0, drained}, 32'd1);
        load("st_idle_ovf", ADDR_STATUS, DML_LW, 32'h4);
        store(ADDR_STATUS, 32'h0, DMS_B);
        load("st_idle_clr", ADDR_STATUS, DML_LW, 32'h0);

        // Reset in the middle of a frame with bytes queued
        store(ADDR_TXDATA, 32'h3C, DMS_W);
        store(ADDR_TXDATA, 32'h5A, DMS_W);
        store(ADDR_TXDATA, 32'h0F, DMS_W);
        drive(ADDR_STATUS, 32'h0, 1'b0, DMS_NOP, DML_LW);
        wait_tx_low("rst_frame_start");
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_tx", {31'd0, uart_tx}, 32'd1);
        check("midrst_busy", {31'd0, tx_busy}, 32'd0);
        check("midrst_status", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bad_tx = 0;
        bad_busy = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #1;
            if (uart_tx !== 1'b1) bad_tx++;
            if (tx_busy !== 1'b0) bad_busy++;
        end
        check("postrst_tx_bad", bad_tx, 0);
        check("postrst_busy_bad", bad_busy, 0);
        load("postrst_ram", 32'h1001_0004, DML_LW, 32'h9876_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
